// File: rtl/toggle_event_rx_pkg.sv
// Shared types and defaults for the toggle-encoded event receiver.
// Holds the pending-counter state encoding and default parameter values.
package toggle_event_rx_pkg;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PENDING = 2'd1,
        FULL    = 2'd2
    } state_t;

endpackage

// File: rtl/toggle_event_rx_sync_ff.sv
// N-flop single-bit synchronizer with asynchronous active-high reset.
// Reusable by any block that brings a level across a clock domain.
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff <= '0;
        end else begin
            ff <= {ff[N-2:0], d};
        end
    end

    assign q = ff[N-1];

endmodule

// File: rtl/toggle_event_rx.sv
// Receiver for a toggle-encoded event line: edge decode, pending
// event counter with saturation/overflow, and consumer handshake.
module toggle_event_rx
    import toggle_event_rx_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_in,
    input  logic             ack,
    input  logic             clr_ovf,
    output logic             pulse,
    output logic             evt_valid,
    output logic [CNT_W-1:0] evt_count,
    output logic             overflow,
    output logic             q,
    output logic             qbar
);

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             t_sync;
    logic [CNT_W-1:0] count;
    state_t           state;
    logic             acc;
    logic             inc;
    logic             dec;

    sync_ff #(
        .N(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (t_in),
        .q    (t_sync)
    );

    // q holds the reference level; any difference is one event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q     <= 1'b0;
            pulse <= 1'b0;
        end else begin
            q     <= t_sync;
            pulse <= t_sync ^ q;
        end
    end

    assign qbar      = ~q;
    assign evt_valid = (count != '0);
    assign evt_count = count;

    assign acc = ack & evt_valid;
    assign inc = pulse & ~acc;
    assign dec = acc & ~pulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (inc && state == FULL) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
            unique case (state)
                EMPTY: begin
                    if (inc) begin
                        count <= count + ONE;
                        state <= (count == MAX - ONE) ? FULL : PENDING;
                    end
                end
                PENDING: begin
                    if (inc) begin
                        count <= count + ONE;
                        if (count == MAX - ONE) begin
                            state <= FULL;
                        end
                    end else if (dec) begin
                        count <= count - ONE;
                        if (count == ONE) begin
                            state <= EMPTY;
                        end
                    end
                end
                FULL: begin
                    if (dec) begin
                        count <= count - ONE;
                        state <= (count == ONE) ? EMPTY : PENDING;
                    end
                end
                default: begin
                    state <= EMPTY;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_event_rx.sv
// Bench for toggle_event_rx: default instance plus a CNT_W=2 instance.
module tb_toggle_event_rx;
    import toggle_event_rx_pkg::*;

    localparam int S = 2;

    logic       clk;
    logic       reset;
    logic       tin0, ack0, clr0;
    logic       tin1, ack1, clr1;
    logic       pulse0, valid0, ovf0, q0, qb0;
    logic       pulse1, valid1, ovf1, q1, qb1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    int errors = 0;
    int checks = 0;

    int mcnt   [2];
    bit movf   [2];
    bit mpulse [2];
    bit mq     [2];
    int nsmp   [2];
    bit hist   [2][4096];

    toggle_event_rx dut (
        .clk      (clk),
        .reset    (reset),
        .t_in     (tin0),
        .ack      (ack0),
        .clr_ovf  (clr0),
        .pulse    (pulse0),
        .evt_valid(valid0),
        .evt_count(cnt0),
        .overflow (ovf0),
        .q        (q0),
        .qbar     (qb0)
    );

    toggle_event_rx #(
        .CNT_W(2)
    ) dut2 (
        .clk      (clk),
        .reset    (reset),
        .t_in     (tin1),
        .ack      (ack1),
        .clr_ovf  (clr1),
        .pulse    (pulse1),
        .evt_valid(valid1),
        .evt_count(cnt1),
        .overflow (ovf1),
        .q        (q1),
        .qbar     (qb1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mcnt[i]   = 0;
            movf[i]   = 0;
            mpulse[i] = 0;
            mq[i]     = 0;
            nsmp[i]   = 0;
        end
    endtask

    // Behaviour at one clock edge, from the event-counting rules
    task automatic model_edge(int i, bit tin, bit ak, bit cl);
        int maxc = (i == 0) ? 255 : 3;
        bit acc  = ak && (mcnt[i] > 0);
        bit lost = mpulse[i] && !acc && (mcnt[i] == maxc);
        bit nq;
        if (mpulse[i] && !acc && !lost) mcnt[i]++;
        else if (acc && !mpulse[i]) mcnt[i]--;
        if (lost) movf[i] = 1;
        else if (cl) movf[i] = 0;
        if (nsmp[i] < 4096) begin
            hist[i][nsmp[i]] = tin;
            nsmp[i]++;
        end
        nq = (nsmp[i] > S) ? hist[i][nsmp[i]-1-S] : 1'b0;
        mpulse[i] = (nq != mq[i]);
        mq[i] = nq;
    endtask

    task automatic check_all(int i);
        logic       p, qq, qb, v, o;
        logic [7:0] c;
        state_t     st, est;
        int         maxc = (i == 0) ? 255 : 3;
        if (i == 0) begin
            p = pulse0; qq = q0; qb = qb0; v = valid0; o = ovf0;
            c = cnt0; st = dut.state;
        end else begin
            p = pulse1; qq = q1; qb = qb1; v = valid1; o = ovf1;
            c = {6'b0, cnt1}; st = dut2.state;
        end
        est = (mcnt[i] == 0) ? EMPTY : (mcnt[i] == maxc) ? FULL : PENDING;
        chk(i ? "d2_pulse" : "d1_pulse", 32'(p), int'(mpulse[i]));
        chk(i ? "d2_q" : "d1_q", 32'(qq), int'(mq[i]));
        chk(i ? "d2_qbar" : "d1_qbar", 32'(qb), int'(!mq[i]));
        chk(i ? "d2_count" : "d1_count", 32'(c), mcnt[i]);
        chk(i ? "d2_valid" : "d1_valid", 32'(v), int'(mcnt[i] != 0));
        chk(i ? "d2_ovf" : "d1_ovf", 32'(o), int'(movf[i]));
        chk(i ? "d2_state" : "d1_state", 32'(st), int'(est));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, tin0, ack0, clr0);
        model_edge(1, tin1, ack1, clr1);
        #1;
        check_all(0);
        check_all(1);
    endtask

    initial begin
        int pidx;
        reset = 1'b1;
        tin0 = 0; ack0 = 0; clr0 = 0;
        tin1 = 0; ack1 = 0; clr1 = 0;
        #1;
        model_reset();
        check_all(0);
        check_all(1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // single toggle: pulse appears after the third sampling edge
        step();
        tin0 = 1;
        pidx = -1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (pulse0 === 1'b1 && pidx < 0) pidx = k;
        end
        chk("first_pulse_edge", 32'(pidx), 3);
        chk("first_count", 32'(cnt0), 1);

        // three spaced toggles, then drain with ack held
        for (int t = 0; t < 3; t++) begin
            tin0 = ~tin0;
            for (int k = 0; k < 4; k++) step();
        end
        step();
        step();
        chk("three_toggles_count", 32'(cnt0), 4);
        ack0 = 1;
        for (int k = 0; k < 6; k++) step();
        ack0 = 0;
        chk("drained_valid", 32'(valid0), 0);

        // build up to 5, then pulse and ack coincide
        for (int t = 0; t < 5; t++) begin
            tin0 = ~tin0;
            for (int k = 0; k < 4; k++) step();
        end
        step();
        step();
        tin0 = ~tin0;
        for (int k = 0; k < 10 && !mpulse[0]; k++) step();
        ack0 = 1;
        step();
        ack0 = 0;
        chk("coincide_count", 32'(cnt0), 5);
        chk("coincide_ovf", 32'(ovf0), 0);

        // small counter saturates and flags overflow
        for (int t = 0; t < 4; t++) begin
            tin1 = ~tin1;
            for (int k = 0; k < 4; k++) step();
        end
        step();
        chk("sat_count", 32'(cnt1), 3);
        chk("sat_ovf", 32'(ovf1), 1);
        clr1 = 1;
        step();
        clr1 = 0;
        chk("clr_ovf", 32'(ovf1), 0);
        chk("clr_count", 32'(cnt1), 3);

        // async reset mid-cycle with a toggle inside the synchronizer
        ack0 = 1;
        for (int k = 0; k < 20 && mcnt[0] > 2; k++) step();
        ack0 = 0;
        tin0 = ~tin0;
        step();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(0);
        check_all(1);
        tin0 = 0;
        tin1 = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) step();

        // ack with nothing pending is ignored
        ack0 = 1;
        for (int k = 0; k < 10; k++) step();
        ack0 = 0;
        chk("idle_ack_count", 32'(cnt0), 0);

        // resync: t_in already high when reset releases
        reset = 1'b1;
        tin1 = 1;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("resync_count", 32'(cnt1), 1);

        // random traffic on both instances
        for (int k = 0; k < 400; k++) begin
            if ($urandom % 4 == 0) tin0 = ~tin0;
            if ($urandom % 3 == 0) tin1 = ~tin1;
            ack0 = ($urandom % 3 == 0);
            ack1 = ($urandom % 7 == 0);
            clr0 = ($urandom % 16 == 0);
            clr1 = ($urandom % 16 == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/toggle_event_rx.md
TOGGLE_EVENT_RX -- requirements
Module: toggle_event_rx

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on t_in (legal range 2..4).
REQ-002 The block SHALL have parameter CNT_W, default 8, width of the pending-event counter.
REQ-003 Port clk, input, 1 bit: the only clock; all flops are rising-edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port t_in, input, 1 bit: toggle-encoded event line from a T-flip-flop sender; asynchronous to clk.
REQ-006 Port ack, input, 1 bit: consumer accepts one event when sampled high with evt_valid high.
REQ-007 Port clr_ovf, input, 1 bit: synchronous clear of overflow.
REQ-008 Port pulse, output reg, 1 bit: one-cycle strobe per detected toggle.
REQ-009 Port evt_valid, output, 1 bit: at least one unacknowledged event is pending.
REQ-010 Port evt_count, output, CNT_W bits: number of pending events.
REQ-011 Port overflow, output reg, 1 bit: sticky flag for an event lost at saturation.
REQ-012 Port q, output reg, 1 bit: synchronized copy of the sender's toggle level.
REQ-013 Port qbar, output, 1 bit: always ~q, including during reset.

Function
REQ-014 The block SHALL decode each level change of t_in, rising or falling, as exactly one event.
REQ-015 The block SHALL pass t_in through SYNC_STAGES flops before any other logic uses it.
REQ-016 For SYNC_STAGES=2, a t_in change stable before edge k SHALL assert pulse for exactly one cycle, from edge k+2 to edge k+3; q SHALL update at edge k+2.
REQ-017 pulse SHALL be the registered XOR of the last synchronizer stage and q.
REQ-018 On each pulse, the pending counter SHALL increment by 1.
REQ-019 An accepted ack (ack=1 and evt_valid=1 at an edge) SHALL decrement the pending counter by 1.
REQ-020 If pulse and an accepted ack coincide, the counter SHALL hold and overflow SHALL NOT set.
REQ-021 ack while evt_valid=0 SHALL be ignored; the counter SHALL never wrap below 0.
REQ-022 At 2^CNT_W-1, a pulse without an accepted ack SHALL leave the counter unchanged and set overflow at the same edge.
REQ-023 overflow SHALL remain set until clr_ovf is high at an edge.
REQ-024 If clr_ovf and a new overflow event coincide, set SHALL win.
REQ-025 evt_valid SHALL be high exactly when the counter is nonzero.
REQ-026 evt_count SHALL equal the counter register.
REQ-027 The counter SHALL be controlled by a state machine with states EMPTY (count=0), PENDING (0<count<max) and FULL (count=max).
REQ-028 The EMPTY to PENDING transition SHALL occur on a pulse.
REQ-029 The PENDING to EMPTY transition SHALL occur on an accepted ack with no pulse when count=1.
REQ-030 The PENDING to FULL transition SHALL occur on a pulse with no accepted ack when count=max-1.
REQ-031 The FULL to PENDING transition SHALL occur on an accepted ack with no pulse.
REQ-032 The FULL state SHALL be held while pulses arrive with no accepted ack, setting overflow.
REQ-033 All other state and input combinations SHALL hold the current state.

Reset
REQ-034 Asserting reset SHALL immediately, without waiting for clk, clear the synchronizer flops, q, pulse, counter and overflow, and enter state EMPTY.
REQ-035 During reset, qbar SHALL be 1 and evt_valid SHALL be 0.
REQ-036 Events in flight when reset asserts SHALL be discarded.
REQ-037 After reset deasserts, t_in SHALL be taken as the new reference level; a t_in already high SHALL produce one pulse, which the sender and consumer treat as a resync.
REQ-038 Reset deassertion is synchronized to clk outside this block.

Structure
REQ-039 Package toggle_event_rx_pkg SHALL contain the state enumeration (EMPTY, PENDING, FULL) and the default CNT_W and SYNC_STAGES constants.
REQ-040 Sub-module sync_ff SHALL implement the parameterized N-flop synchronizer with asynchronous active-high reset, for reuse by other clock-crossing blocks.
REQ-041 The decoder, counter and FSM SHALL reside in toggle_event_rx.

Verification
REQ-042 Reset, then toggle t_in 0->1 before edge 5 -> pulse high only in cycle 7, q=1 from edge 7, evt_count=1, evt_valid=1.
REQ-043 3 toggles spaced 4 cycles apart with ack=0, then ack held high -> evt_count goes 1,2,3, then 2,1,0 on consecutive edges; evt_valid falls with the last decrement.
REQ-044 Pulse and ack in the same cycle at count=5 -> count stays 5, overflow=0.
REQ-045 CNT_W=2, 4 toggles with no ack -> count saturates at 3, state FULL, overflow=1 at the 4th pulse; clr_ovf alone -> overflow=0, count 3.
REQ-046 Assert reset asynchronously mid-cycle at count=2 with a toggle in the synchronizer -> all outputs reset before the next edge, qbar=1, no pulse after release when t_in=0.
REQ-047 ack at count=0 for 10 cycles -> count stays 0, state EMPTY.
